calculator_chain: RTL and testbench

// - Parametrised successor of the two-operand add/sub calculator: WIDTH-bit operands,

---
 rtl/calculator_chain.sv | 149 ++++++++++++++
 tb/tb_calculator_chain.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/calculator_chain.sv
// Chained two-operand calculator: captures A then B, computes add/sub/and/xor, and holds
// the result under a valid/ready handshake. Define CALC_SAT_EN to saturate add/sub results.
module calculator_chain #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] operand_i,
    input  logic             operand_valid_i,
    output logic             operand_ready_o,
    input  logic [1:0]       op_i,
    input  logic             calc_i,
    input  logic             chain_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             result_valid_o,
    input  logic             result_ready_i
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RDY = 2'd2,
        S_OUT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] value;
    } res_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    res_t             res_q, res_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    res_t             alu_res;

    // Extended-width add/sub: the extra MSB is the carry (add) or borrow (sub).
    always_comb begin
        sum_w   = {1'b0, reg_a_q} + {1'b0, reg_b_q};
        diff_w  = {1'b0, reg_a_q} - {1'b0, reg_b_q};
        alu_res = '0;
        case (op_e'(op_i))
            OP_ADD: begin
                alu_res.carry = sum_w[WIDTH];
`ifdef CALC_SAT_EN
                alu_res.value = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
`else
                alu_res.value = sum_w[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                alu_res.carry = diff_w[WIDTH];
`ifdef CALC_SAT_EN
                alu_res.value = diff_w[WIDTH] ? {WIDTH{1'b0}} : diff_w[WIDTH-1:0];
`else
                alu_res.value = diff_w[WIDTH-1:0];
`endif
            end
            OP_AND:  alu_res.value = reg_a_q & reg_b_q;
            OP_XOR:  alu_res.value = reg_a_q ^ reg_b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        res_d   = res_q;
        valid_d = valid_q;
        // Clear wins over every same-cycle event, including a handshake with chain_i.
        if (clear_i) begin
            state_d = S_A;
            reg_a_d = '0;
            reg_b_d = '0;
            res_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (operand_valid_i) begin
                        reg_a_d = operand_i;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (operand_valid_i) begin
                        reg_b_d = operand_i;
                        state_d = S_RDY;
                    end
                end
                S_RDY: begin
                    if (calc_i) begin
                        res_d   = alu_res;
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (valid_q && result_ready_i) begin
                        valid_d = 1'b0;
                        if (chain_i) begin
                            reg_a_d = res_q.value;
                            state_d = S_B;
                        end else begin
                            state_d = S_A;
                        end
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_A;
            reg_a_q <= '0;
            reg_b_q <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign operand_ready_o = (state_q == S_A) || (state_q == S_B);
    assign result_o        = res_q.value;
    assign carry_o         = res_q.carry;
    assign result_valid_o  = valid_q;

endmodule

// File: tb/tb_calculator_chain.sv
// Directed-vector bench for calculator_chain (WIDTH=8); expectations follow CALC_SAT_EN.
module tb_calculator_chain;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [W-1:0] operand_i = '0;
    logic         operand_valid_i = 1'b0;
    logic         operand_ready_o;
    logic [1:0]   op_i = 2'b00;
    logic         calc_i = 1'b0;
    logic         chain_i = 1'b0;
    logic         clear_i = 1'b0;
    logic [W-1:0] result_o;
    logic         carry_o;
    logic         result_valid_o;
    logic         result_ready_i = 1'b0;

    int tests = 0;
    int fails = 0;

    calculator_chain #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .operand_i(operand_i),
        .operand_valid_i(operand_valid_i), .operand_ready_o(operand_ready_o),
        .op_i(op_i), .calc_i(calc_i), .chain_i(chain_i), .clear_i(clear_i),
        .result_o(result_o), .carry_o(carry_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v);
        operand_i = v; operand_valid_i = 1'b1;
        step();
        operand_valid_i = 1'b0;
    endtask

    task automatic calc(input logic [1:0] op);
        op_i = op; calc_i = 1'b1;
        step();
        calc_i = 1'b0;
    endtask

    task automatic handshake(input logic ch);
        result_ready_i = 1'b1; chain_i = ch;
        step();
        result_ready_i = 1'b0; chain_i = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        tests++; if (result_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", result_valid_o); end
        tests++; if (result_o !== 8'd0) begin fails++; $display("FAIL reset_result got=%0d exp=0", result_o); end
        rst_ni = 1'b1;
        step();
        tests++; if (operand_ready_o !== 1'b1) begin fails++; $display("FAIL reset_opready got=%0b exp=1", operand_ready_o); end
        // Leave a nonzero result, then reset while parked in S_RDY.
        send(8'd3); send(8'd4); calc(2'b00); handshake(1'b0);
        send(8'd1); send(8'd2);
        tests++; if (operand_ready_o !== 1'b0) begin fails++; $display("FAIL rdy_opready got=%0b exp=0", operand_ready_o); end
        rst_ni = 1'b0;
        #1;
        tests++; if (result_o !== 8'd0 || result_valid_o !== 1'b0) begin fails++; $display("FAIL midreset got=%0d/%0b exp=0/0", result_o, result_valid_o); end
        step();
        rst_ni = 1'b1;
        step();
        tests++; if (operand_ready_o !== 1'b1) begin fails++; $display("FAIL midreset_opready got=%0b exp=1", operand_ready_o); end
    endtask

    task automatic test_ops();
        logic [W-1:0] exp_add, exp_sub;
`ifdef CALC_SAT_EN
        exp_add = 8'd255; exp_sub = 8'd0;
`else
        exp_add = 8'd44;  exp_sub = 8'd252;
`endif
        send(8'd200); send(8'd100);
        tests++; if (result_valid_o !== 1'b0) begin fails++; $display("FAIL pre_calc_valid got=%0b exp=0", result_valid_o); end
        calc(2'b00);
        tests++; if (result_valid_o !== 1'b1 || result_o !== exp_add || carry_o !== 1'b1) begin fails++; $display("FAIL add_200_100 got=%0d c=%0b v=%0b exp=%0d c=1 v=1", result_o, carry_o, result_valid_o, exp_add); end
        handshake(1'b0);
        send(8'd5); send(8'd9); calc(2'b01);
        tests++; if (result_o !== exp_sub || carry_o !== 1'b1) begin fails++; $display("FAIL sub_5_9 got=%0d c=%0b exp=%0d c=1", result_o, carry_o, exp_sub); end
        handshake(1'b0);
        send(8'hF0); send(8'h3C); calc(2'b11);
        tests++; if (result_o !== 8'hCC || carry_o !== 1'b0) begin fails++; $display("FAIL xor got=%0h c=%0b exp=cc c=0", result_o, carry_o); end
        handshake(1'b0);
        send(8'hF0); send(8'h3C); calc(2'b10);
        tests++; if (result_o !== 8'h30 || carry_o !== 1'b0) begin fails++; $display("FAIL and got=%0h c=%0b exp=30 c=0", result_o, carry_o); end
        handshake(1'b0);
        send(8'd20); send(8'd7); calc(2'b01);
        tests++; if (result_o !== 8'd13 || carry_o !== 1'b0) begin fails++; $display("FAIL sub_20_7 got=%0d c=%0b exp=13 c=0", result_o, carry_o); end
        handshake(1'b0);
    endtask

    task automatic test_chain();
        send(8'd10); send(8'd20); calc(2'b00);
        tests++; if (result_o !== 8'd30) begin fails++; $display("FAIL chain_first got=%0d exp=30", result_o); end
        handshake(1'b1);
        tests++; if (operand_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin fails++; $display("FAIL chain_hs got ready=%0b v=%0b exp 1/0", operand_ready_o, result_valid_o); end
        calc(2'b00);
        tests++; if (result_valid_o !== 1'b0) begin fails++; $display("FAIL calc_in_sb got=%0b exp=0", result_valid_o); end
        send(8'd5); calc(2'b00);
        tests++; if (result_o !== 8'd35 || result_valid_o !== 1'b1) begin fails++; $display("FAIL chain_sum got=%0d v=%0b exp=35 v=1", result_o, result_valid_o); end
        handshake(1'b0);
        send(8'd1); send(8'd1); calc(2'b00);
        tests++; if (result_o !== 8'd2) begin fails++; $display("FAIL unchain_to_sa got=%0d exp=2", result_o); end
        handshake(1'b0);
    endtask

    task automatic test_backpressure();
        send(8'd60); send(8'd70); calc(2'b00);
        for (int i = 0; i < 3; i++) begin
            operand_i = 8'd99; operand_valid_i = i[0];
            op_i = 2'b11; calc_i = 1'b1;
            step();
            tests++; if (result_o !== 8'd130 || carry_o !== 1'b0 || result_valid_o !== 1'b1 || operand_ready_o !== 1'b0) begin fails++; $display("FAIL hold_%0d got=%0d c=%0b v=%0b r=%0b exp=130 c=0 v=1 r=0", i, result_o, carry_o, result_valid_o, operand_ready_o); end
        end
        operand_valid_i = 1'b0; calc_i = 1'b0;
        handshake(1'b0);
        tests++; if (result_valid_o !== 1'b0 || result_o !== 8'd130) begin fails++; $display("FAIL bp_release got=%0d v=%0b exp=130 v=0", result_o, result_valid_o); end
        tests++; if (dut.reg_b_q !== 8'd70) begin fails++; $display("FAIL bp_regb got=%0d exp=70", dut.reg_b_q); end
    endtask

    task automatic test_clear();
        send(8'd7);
        operand_i = 8'd9; operand_valid_i = 1'b1; clear_i = 1'b1;
        step();
        operand_valid_i = 1'b0; clear_i = 1'b0;
        tests++; if (operand_ready_o !== 1'b1 || dut.reg_a_q !== 8'd0 || dut.reg_b_q !== 8'd0 || result_o !== 8'd0) begin fails++; $display("FAIL clear_capture got a=%0d b=%0d res=%0d exp 0/0/0", dut.reg_a_q, dut.reg_b_q, result_o); end
        send(8'd1); send(8'd2); calc(2'b00);
        tests++; if (result_o !== 8'd3) begin fails++; $display("FAIL clear_then_sa got=%0d exp=3", result_o); end
        handshake(1'b0);
        send(8'd50); send(8'd60); calc(2'b00);
        result_ready_i = 1'b1; chain_i = 1'b1; clear_i = 1'b1;
        step();
        result_ready_i = 1'b0; chain_i = 1'b0; clear_i = 1'b0;
        tests++; if (result_valid_o !== 1'b0 || result_o !== 8'd0 || carry_o !== 1'b0 || dut.reg_a_q !== 8'd0) begin fails++; $display("FAIL clear_hs got v=%0b res=%0d c=%0b a=%0d exp 0/0/0/0", result_valid_o, result_o, carry_o, dut.reg_a_q); end
        send(8'd3); send(8'd4); calc(2'b00);
        tests++; if (result_o !== 8'd7) begin fails++; $display("FAIL clear_no_chain got=%0d exp=7", result_o); end
        handshake(1'b0);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_chain();
        test_backpressure();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
